// File: rtl/k12a_spi_target_if.sv
// CPU-side I/O strobes and register select for the k12a SPI target.
interface k12a_spi_target_if;
   logic io_load;
   logic io_store;
   logic io_addr;

   modport slave  (input  io_load, io_store, io_addr);
   modport master (output io_load, io_store, io_addr);
endinterface

// File: rtl/k12a_spi_target.sv
// Mode-0 SPI target on the k12a I/O bus: rx holding register, tx register, status.
// Optional irq output and irq mask bit are built when K12A_SPI_TARGET_IRQ_EN is defined.
module k12a_spi_target (
   input  logic              cpu_clock,
   input  logic              reset,
   k12a_spi_target_if.slave  io,
   inout  wire  [7:0]        data_bus,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   input  logic              spi_cs_n,
   output logic              spi_miso
`ifdef K12A_SPI_TARGET_IRQ_EN
   ,
   output logic              irq
`endif
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t      state;
   state_t      state_next;

   logic        sck_s1, sck_s2, sck_s3;
   logic        mosi_s1, mosi_s2;
   logic        cs_s1, cs_s2;
   logic [1:0]  sync_warm;
   logic        armed;

   logic [7:0]  rx_shift;
   logic [7:0]  tx_shift;
   logic [2:0]  bit_count;
   logic [7:0]  rx_data;
   logic [7:0]  tx_reg;
   logic        rx_full;
   logic        tx_empty;
   logic        overrun;
   logic        mask_bit;

   logic        active;
   logic        busy;
   logic        sck_rise, sck_fall;
   logic        frame_start;
   logic        shift_in, shift_out;
   logic        byte_done, accept;
   logic        tx_reload;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_next_byte;
   logic        load_data, store_data, store_ctrl;
   logic [7:0]  status;
   logic [7:0]  read_value;

   // armed only rises once the CS pipeline holds real pin samples and has seen CS high,
   // so a CS held low across reset does not start a frame.
   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         sck_s1    <= 1'b0;
         sck_s2    <= 1'b0;
         sck_s3    <= 1'b0;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
         cs_s1     <= 1'b1;
         cs_s2     <= 1'b1;
         sync_warm <= '0;
         armed     <= 1'b0;
      end else begin
         sck_s1    <= spi_sck;
         sck_s2    <= sck_s1;
         sck_s3    <= sck_s2;
         mosi_s1   <= spi_mosi;
         mosi_s2   <= mosi_s1;
         cs_s1     <= spi_cs_n;
         cs_s2     <= cs_s1;
         sync_warm <= {sync_warm[0], 1'b1};
         if (sync_warm[1] && cs_s2)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge cpu_clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (armed && !cs_s2) state_next = ACTIVE;
         ACTIVE:  if (cs_s2)           state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign active       = (state == ACTIVE);
   assign busy         = active;
   assign sck_rise     = sck_s2 & ~sck_s3;
   assign sck_fall     = ~sck_s2 & sck_s3;
   assign frame_start  = (state == IDLE) && armed && !cs_s2;
   assign shift_in     = active && !cs_s2 && sck_rise;
   assign shift_out    = active && !cs_s2 && sck_fall;
   assign rx_byte      = {rx_shift[6:0], mosi_s2};
   assign byte_done    = shift_in && (bit_count == 3'd7);
   assign load_data    = io.io_load  & ~io.io_addr;
   assign store_data   = io.io_store & ~io.io_addr;
   assign store_ctrl   = io.io_store &  io.io_addr;
   // A same-cycle data read frees the holding register, so the new byte is taken, not dropped.
   assign accept       = byte_done && (!rx_full || load_data);
   assign tx_reload    = frame_start || (shift_out && (bit_count == 3'd0));
   assign tx_next_byte = tx_empty ? 8'hFF : tx_reg;

   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         rx_shift  <= '0;
         tx_shift  <= '1;
         bit_count <= '0;
         rx_data   <= '0;
         tx_reg    <= '0;
         rx_full   <= 1'b0;
         tx_empty  <= 1'b1;
         overrun   <= 1'b0;
      end else begin
         if (!active || cs_s2) begin
            bit_count <= '0;
         end else if (shift_in) begin
            rx_shift  <= rx_byte;
            bit_count <= bit_count + 3'd1;
         end

         if (tx_reload)
            tx_shift <= tx_next_byte;
         else if (shift_out)
            tx_shift <= {tx_shift[6:0], 1'b1};

         if (store_data) begin
            tx_reg   <= data_bus;
            tx_empty <= 1'b0;
         end else if (tx_reload) begin
            tx_empty <= 1'b1;
         end

         if (accept) begin
            rx_data <= rx_byte;
            rx_full <= 1'b1;
         end else if (load_data) begin
            rx_full <= 1'b0;
         end

         if (byte_done && !accept)
            overrun <= 1'b1;
         else if (store_ctrl && data_bus[3])
            overrun <= 1'b0;
      end
   end

`ifdef K12A_SPI_TARGET_IRQ_EN
   logic irq_mask;

   always_ff @(posedge cpu_clock) begin
      if (reset) begin
         irq_mask <= 1'b0;
         irq      <= 1'b0;
      end else begin
         if (store_ctrl)
            irq_mask <= data_bus[4];
         irq <= (rx_full | overrun) & ~irq_mask;
      end
   end

   assign mask_bit = irq_mask;
`else
   assign mask_bit = 1'b0;
`endif

   assign status     = {3'b000, mask_bit, overrun, busy, tx_empty, rx_full};
   assign read_value = io.io_addr ? status : rx_data;
   assign data_bus   = io.io_load ? read_value : 8'hzz;
   assign spi_miso   = active ? tx_shift[7] : 1'b1;

endmodule
